// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares one single-port synchronous RAM among NUM_REQ requesters.
// Round-robin arbitration with an optional per-requester lock for
// read-modify-write sequences. One access is accepted per cycle at most.
// The RAM command is registered one cycle after accept. Read data is
// returned on RDATA/RVALID one cycle after that, alongside the RAM's own
// synchronous read output.

module ram_access_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 15
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ-1:0]        WE,
    input  logic [NUM_REQ-1:0]        LOCK,
    input  logic [NUM_REQ*ADDR_W-1:0] ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] WDATA,
    output logic [NUM_REQ-1:0]        GNT,
    output logic [NUM_REQ-1:0]        RVALID,
    output logic [DATA_W-1:0]         RDATA,
    output logic                      MEM_EN,
    output logic                      MEM_WE,
    output logic [ADDR_W-1:0]         MEM_ADDR,
    output logic [DATA_W-1:0]         MEM_WDATA,
    input  logic [DATA_W-1:0]         MEM_RDATA
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]   count, count_nxt;

    logic               rr_found;
    logic [PTR_W-1:0]   rr_idx;
    logic [PTR_W-1:0]   rr_cand;

    logic               acc;
    logic [PTR_W-1:0]   gidx;
    logic               lock_expired;

    logic [PTR_W-1:0]   s1_id;
    logic               s2_rd;
    logic [PTR_W-1:0]   s2_id;

    // Next requester index after i, wrapping NUM_REQ-1 back to 0.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
        if (int'(i) == NUM_REQ - 1)
            return '0;
        else
            return i + PTR_W'(1);
    endfunction

    // Round-robin search: first requesting index at or after ptr.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!rr_found && REQ[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // The locking accept is the first owned cycle, so the owner gets at most
    // LOCK_MAX grants in total: release is forced on locked cycle LOCK_MAX-1.
    assign lock_expired = (int'(count) + 1 >= LOCK_MAX - 1);

    // Grant selection and next-state logic for the lock FSM.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // the values just computed; clocked blocks use '<=' only.
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        count_nxt = count;
        acc       = 1'b0;
        gidx      = '0;
        GNT       = '0;

        if (RST_N) begin
            case (state)
                IDLE: begin
                    acc  = rr_found;
                    gidx = rr_idx;
                end
                LOCKED: begin
                    acc  = REQ[owner];
                    gidx = owner;
                end
            endcase
        end

        if (acc)
            GNT[gidx] = 1'b1;

        case (state)
            IDLE: begin
                if (acc) begin
                    if (LOCK[gidx]) begin
                        state_nxt = LOCKED;
                        owner_nxt = gidx;
                        count_nxt = '0;
                    end else begin
                        ptr_nxt = wrap_inc(gidx);
                    end
                end
            end
            LOCKED: begin
                // LOCK dropped covers both the final unlocked access and the
                // owner giving up without requesting.
                if (!LOCK[owner] || lock_expired) begin
                    state_nxt = IDLE;
                    ptr_nxt   = wrap_inc(owner);
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            count <= count_nxt;
        end
    end

    // RAM command stage plus read-return tracking stage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            s1_id     <= '0;
            s2_rd     <= 1'b0;
            s2_id     <= '0;
        end else begin
            MEM_EN <= acc;
            MEM_WE <= acc & WE[gidx];
            if (acc) begin
                MEM_ADDR  <= ADDR[gidx*ADDR_W +: ADDR_W];
                MEM_WDATA <= WDATA[gidx*DATA_W +: DATA_W];
                s1_id     <= gidx;
            end
            s2_rd <= MEM_EN & ~MEM_WE;
            s2_id <= s1_id;
        end
    end

    // Read return: the RAM output is valid in the cycle after a read command.
    always_comb begin
        RVALID = '0;
        if (s2_rd)
            RVALID[s2_id] = 1'b1;
    end

    assign RDATA = s2_rd ? MEM_RDATA : '0;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
// Directed bench for ram_access_arbiter with a behavioural synchronous RAM.
// Inputs change 1 ns after each rising edge and outputs are sampled 1 ns later.

module tb_ram_access_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 16;
    localparam int LOCK_MAX = 4;

    logic                      CLK;
    logic                      RST_N;
    logic [NUM_REQ-1:0]        REQ;
    logic [NUM_REQ-1:0]        WE;
    logic [NUM_REQ-1:0]        LOCK;
    logic [NUM_REQ*ADDR_W-1:0] ADDR;
    logic [NUM_REQ*DATA_W-1:0] WDATA;
    logic [NUM_REQ-1:0]        GNT;
    logic [NUM_REQ-1:0]        RVALID;
    logic [DATA_W-1:0]         RDATA;
    logic                      MEM_EN;
    logic                      MEM_WE;
    logic [ADDR_W-1:0]         MEM_ADDR;
    logic [DATA_W-1:0]         MEM_WDATA;
    logic [DATA_W-1:0]         mem_rdata;

    logic [DATA_W-1:0]         ram [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;

    ram_access_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ       (REQ),
        .WE        (WE),
        .LOCK      (LOCK),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .GNT       (GNT),
        .RVALID    (RVALID),
        .RDATA     (RDATA),
        .MEM_EN    (MEM_EN),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single-port synchronous RAM: read data appears the cycle after the command.
    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE)
                ram[MEM_ADDR] <= MEM_WDATA;
            else
                mem_rdata <= ram[MEM_ADDR];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input int i, input logic we, input logic lk,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        REQ[i]                = 1'b1;
        WE[i]                 = we;
        LOCK[i]               = lk;
        ADDR[i*ADDR_W +: ADDR_W]  = a;
        WDATA[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic drop(input int i);
        REQ[i]  = 1'b0;
        LOCK[i] = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0;
        REQ   = '0;
        WE    = '0;
        LOCK  = '0;
        ADDR  = '0;
        WDATA = '0;
        mem_rdata = '0;

        // Reset state: everything quiet even with all requests raised.
        tick(); tick();
        REQ = 4'b1111;
        #1;
        check("rst_gnt",    32'(GNT),      32'h0);
        check("rst_mem_en", 32'(MEM_EN),   32'h0);
        check("rst_rvalid", 32'(RVALID),   32'h0);
        check("rst_rdata",  32'(RDATA),    32'h0);
        check("rst_addr",   32'(MEM_ADDR), 32'h0);
        REQ = '0;

        // Reset in the middle of a read.
        tick();
        RST_N = 1'b1;
        put(1, 1'b0, 1'b0, 14'h0005, 16'h0000);
        #1;
        check("mid_gnt", 32'(GNT), 32'h2);
        tick();
        drop(1);
        #1;
        check("mid_mem_en", 32'(MEM_EN), 32'h1);
        RST_N = 1'b0;
        REQ   = 4'b1111;
        #1;
        check("mid_rst_mem_en", 32'(MEM_EN),   32'h0);
        check("mid_rst_addr",   32'(MEM_ADDR), 32'h0);
        check("mid_rst_gnt",    32'(GNT),      32'h0);
        check("mid_rst_rvalid", 32'(RVALID),   32'h0);
        REQ = '0;
        tick();
        #1;
        check("mid_rst_rvalid2", 32'(RVALID), 32'h0);
        tick();
        RST_N = 1'b1;
        put(1, 1'b0, 1'b0, 14'h0007, 16'h0000);
        put(3, 1'b0, 1'b0, 14'h0009, 16'h0000);
        #1;
        check("post_rst_gnt",    32'(GNT),    32'h2);
        check("post_rst_rvalid", 32'(RVALID), 32'h0);
        tick();
        drop(1);
        drop(3);
        #1;
        check("post_rst_addr",    32'(MEM_ADDR), 32'h0007);
        check("post_rst_rvalid1", 32'(RVALID),   32'h0);
        tick();
        #1;
        check("post_rst_rd_ret", 32'(RVALID), 32'h2);

        // Read latency: preload 0x0123 by a write, then read it back via req 2.
        tick();
        put(2, 1'b1, 1'b0, 14'h0123, 16'hBEEF);
        #1;
        check("wr_gnt", 32'(GNT), 32'h4);
        tick();
        put(2, 1'b0, 1'b0, 14'h0123, 16'h0000);
        #1;
        check("wr_mem_en",  32'(MEM_EN),    32'h1);
        check("wr_mem_we",  32'(MEM_WE),    32'h1);
        check("wr_addr",    32'(MEM_ADDR),  32'h0123);
        check("wr_wdata",   32'(MEM_WDATA), 32'hBEEF);
        check("rd_gnt",     32'(GNT),       32'h4);
        tick();
        drop(2);
        #1;
        check("rd_mem_en",  32'(MEM_EN),   32'h1);
        check("rd_mem_we",  32'(MEM_WE),   32'h0);
        check("rd_addr",    32'(MEM_ADDR), 32'h0123);
        check("rd_rvalid1", 32'(RVALID),   32'h0);
        tick();
        #1;
        check("rd_rvalid",  32'(RVALID), 32'h4);
        check("rd_rdata",   32'(RDATA),  32'hBEEF);
        check("rd_idle_en", 32'(MEM_EN), 32'h0);

        // Write then read of the same address from different requesters.
        tick();
        put(3, 1'b1, 1'b0, 14'h0010, 16'h1234);
        #1;
        check("wo_gnt3", 32'(GNT), 32'h8);
        tick();
        drop(3);
        put(0, 1'b0, 1'b0, 14'h0010, 16'h0000);
        #1;
        check("wo_gnt0",  32'(GNT),       32'h1);
        check("wo_we",    32'(MEM_WE),    32'h1);
        check("wo_wdata", 32'(MEM_WDATA), 32'h1234);
        tick();
        drop(0);
        #1;
        check("wo_rd_we",   32'(MEM_WE), 32'h0);
        check("wo_no_rval", 32'(RVALID), 32'h0);
        tick();
        #1;
        check("wo_rvalid", 32'(RVALID), 32'h1);
        check("wo_rdata",  32'(RDATA),  32'h1234);

        // Locked read-modify-write by req 1 with req 0 and req 3 waiting.
        tick();
        put(0, 1'b0, 1'b0, 14'h0020, 16'h0000);
        put(3, 1'b0, 1'b0, 14'h0030, 16'h0000);
        put(1, 1'b0, 1'b1, 14'h0040, 16'h0000);
        #1;
        check("lk_gnt_rd", 32'(GNT), 32'h2);
        tick();
        put(1, 1'b1, 1'b0, 14'h0040, 16'h5555);
        #1;
        check("lk_gnt_wr", 32'(GNT),    32'h2);
        check("lk_rd_cmd", 32'(MEM_WE), 32'h0);
        tick();
        drop(1);
        #1;
        check("lk_gnt_next", 32'(GNT),       32'h8);
        check("lk_wr_data",  32'(MEM_WDATA), 32'h5555);
        check("lk_rvalid",   32'(RVALID),    32'h2);
        tick();
        drop(0);
        drop(3);
        #1;
        check("lk_gnt_none", 32'(GNT),      32'h0);
        check("lk_addr3",    32'(MEM_ADDR), 32'h0030);

        // Round-robin rotation with every requester reading continuously.
        tick();
        for (int i = 0; i < NUM_REQ; i++)
            put(i, 1'b0, 1'b0, ADDR_W'(14'h0100 + i), 16'h0000);
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_gnt%0d", k), 32'(GNT), 32'(1 << (k % 4)));
            if (k >= 1)
                check($sformatf("rr_addr%0d", k), 32'(MEM_ADDR), 32'(14'h0100 + (k - 1) % 4));
            if (k >= 2)
                check($sformatf("rr_rval%0d", k), 32'(RVALID), 32'(1 << ((k - 2) % 4)));
            tick();
        end
        REQ = '0;
        #1;
        check("rr_addr_last", 32'(MEM_ADDR), 32'h0103);
        check("rr_gnt_none",  32'(GNT),      32'h0);

        // Lock timeout: req 0 keeps LOCK high, req 1 waits from the start.
        tick();
        put(0, 1'b0, 1'b1, 14'h0200, 16'h0000);
        put(1, 1'b0, 1'b0, 14'h0201, 16'h0000);
        for (int k = 0; k < LOCK_MAX; k++) begin
            #1;
            check($sformatf("to_gnt0_%0d", k), 32'(GNT), 32'h1);
            tick();
        end
        #1;
        check("to_gnt1", 32'(GNT), 32'h2);
        tick();
        drop(1);
        #1;
        check("to_regrant0", 32'(GNT), 32'h1);
        drop(0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
